// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-look-ahead adder: slice width,
// FSM state encodings and the index-width helper.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of the slice index counter; never narrower than one bit.
  function automatic int idx_width(input int num_slices);
    int w;
    w = $clog2(num_slices);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit generate/propagate carry-look-ahead slice.
// Also exports c3, the carry into bit 3, for signed-overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat function of g/p/ci, with no ripple inside the slice.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/cla_serial_adder.sv
// Serial multi-word adder: one 4-bit CLA slice per clock, LSB slice first.
// Define CLA_SERIAL_OVF_EN to add the signed-overflow output ovf.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
`ifdef CLA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W      = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [IDX_W-1:0]   idx;
  logic               carry_reg;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               slice_c3;

  cla4_slice u_slice (
    .a  (a_sh[SLICE_W-1:0]),
    .b  (b_sh[SLICE_W-1:0]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign carry     = carry_reg;

`ifndef CLA_SERIAL_OVF_EN
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  // Operands shift right so the active slice is always in the low nibble;
  // the inter-slice carry lives only in carry_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
`ifdef CLA_SERIAL_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            idx       <= '0;
            sum       <= '0;
`ifdef CLA_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
            state     <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx == IDX_W'(i)) sum[i*SLICE_W +: SLICE_W] <= slice_s;
          end
          carry_reg <= slice_co;
          a_sh      <= a_sh >> SLICE_W;
          b_sh      <= b_sh >> SLICE_W;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
`ifdef CLA_SERIAL_OVF_EN
            ovf   <= slice_c3 ^ slice_co;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
`ifdef CLA_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder (WIDTH=16): directed and random operands
// checked against plain integer addition; ovf checks appear with CLA_SERIAL_OVF_EN.
module tb_cla_serial_adder;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;
`ifdef CLA_SERIAL_OVF_EN
  logic             ovf;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   rand_bp = 1'b0;

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .busy      (busy)
`ifdef CLA_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the whole word added at once with integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    exp_t e;
    logic [WIDTH:0] full;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    e.s = full[WIDTH-1:0];
    e.c = full[WIDTH];
    e.o = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end else begin
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      sb.push_back(model(x, y, ci));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    out_ready = 1'b1;
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: got sum %0h with no pending op", sum);
      end else begin
        e = sb.pop_front();
        checkOutput("sum", 32'(sum), 32'(e.s));
        checkOutput("carry", 32'(carry), 32'(e.c));
`ifdef CLA_SERIAL_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(e.o));
`endif
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sum", 32'(sum), 32'h0);
    checkOutput("rst_carry", 32'(carry), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
`ifdef CLA_SERIAL_OVF_EN
    checkOutput("rst_ovf", 32'(ovf), 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

    // Latency: result valid exactly four edges after accept
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("lat_early_valid", 32'(out_valid), 32'h0);
    end
    @(posedge clk); #1;
    checkOutput("lat_valid", 32'(out_valid), 32'h1);
    drain(20);

    // Carry ripples across every slice
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    drain(20);

    // Backpressure: result held, new operands refused
    out_ready = 1'b0;
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b1;
    repeat (3) begin
      checkOutput("bp_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_sum", 32'(sum), 32'hFFFF);
      checkOutput("bp_carry", 32'(carry), 32'h0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    @(posedge clk); #1;
    checkOutput("post_bp_in_ready", 32'(in_ready), 32'h1);
    checkOutput("post_bp_busy", 32'(busy), 32'h0);

    // Reset in the middle of RUN
    applyStimulus(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("mid_rst_sum", 32'(sum), 32'h0);
    checkOutput("mid_rst_carry", 32'(carry), 32'h0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(16'h1234, 16'h4321, 1'b1);
    drain(20);

`ifdef CLA_SERIAL_OVF_EN
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    drain(20);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    drain(20);
`endif

    // Random operands with random result backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain(400);
    rand_bp = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
